// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - fetch controller handshake bundle (PC control, I-cache, fetch FIFO)
// Optional perf outputs exist only when IF_FETCH_PERF_EN is defined.
interface if_fetch_ctrl_if;
  logic        fetch_en;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [63:0] ic_req_pc;
  logic        ic_resp_valid;
  logic [63:0] ic_resp_data;
  logic        buf_enq_valid;
  logic [63:0] buf_enq_data;
  logic        buf_deq_fire;
  logic        buf_flush;
  logic        busy;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  modport master (
    input  fetch_en, stall, redirect_valid, redirect_pc,
    input  ic_req_ready, ic_resp_valid, ic_resp_data, buf_deq_fire,
    output ic_req_valid, ic_req_pc, buf_enq_valid, buf_enq_data, buf_flush, busy
`ifdef IF_FETCH_PERF_EN
    , output perf_issue_cnt, perf_stall_cnt, perf_drop_cnt
`endif
  );

  modport slave (
    output fetch_en, stall, redirect_valid, redirect_pc,
    output ic_req_ready, ic_resp_valid, ic_resp_data, buf_deq_fire,
    input  ic_req_valid, ic_req_pc, buf_enq_valid, buf_enq_data, buf_flush, busy
`ifdef IF_FETCH_PERF_EN
    , input perf_issue_cnt, perf_stall_cnt, perf_drop_cnt
`endif
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - credit-based I-cache fetch sequencer with redirect flush/drain
// Define IF_FETCH_PERF_EN to add saturating issue/stall/drop performance counters.
module if_fetch_ctrl #(
  parameter int          BUF_DEPTH       = 16,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [63:0] RESET_PC        = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_ctrl_if.master bus
);
  localparam int            CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] occupancy, occupancy_nxt;
  logic [CW-1:0] credits;
  logic          req_valid_q, req_valid_nxt;
  logic [63:0]   req_pc_q, req_pc_nxt;
  logic          flush_q;
  logic [63:0]   redirect_pc_al;

  logic in_fetch, redirect, req_accept, resp, enq, deq;
  logic issue_ok, issue_ok_acc, starved;

  assign in_fetch       = (state == ST_FETCH);
  assign redirect       = bus.redirect_valid;
  assign req_accept     = req_valid_q && bus.ic_req_ready;
  assign resp           = bus.ic_resp_valid;
  assign deq            = bus.buf_deq_fire;
  assign redirect_pc_al = {bus.redirect_pc[63:3], 3'b000};

  // A response landing on a redirect cycle belongs to the old stream and is dropped.
  assign enq = !rst && in_fetch && resp && !redirect;

  // occupancy + outstanding never exceeds BUF_DEPTH, so this cannot underflow.
  assign credits = DEPTH_C - occupancy - outstanding;

  assign issue_ok     = in_fetch && !bus.stall && (credits != '0) && (outstanding < MAX_C);
  // Same test, with the request being accepted this cycle already charged.
  assign issue_ok_acc = in_fetch && !bus.stall && (credits > CW'(1))
                        && ((outstanding + CW'(1)) < MAX_C);
  assign starved      = in_fetch && ((credits == '0) || (outstanding >= MAX_C));

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_accept && !resp)
      outstanding_nxt = outstanding + CW'(1);
    else if (!req_accept && resp && (outstanding != '0))
      outstanding_nxt = outstanding - CW'(1);

    occupancy_nxt = occupancy;
    if (redirect)
      occupancy_nxt = '0;
    else if (enq && !deq && (occupancy != DEPTH_C))
      occupancy_nxt = occupancy + CW'(1);
    else if (!enq && deq && (occupancy != '0))
      occupancy_nxt = occupancy - CW'(1);
  end

  // A pending request is held untouched until accepted; only a redirect abandons it.
  always_comb begin
    req_valid_nxt = req_valid_q;
    req_pc_nxt    = req_pc_q;
    if (req_accept) begin
      req_pc_nxt    = req_pc_q + 64'd8;
      req_valid_nxt = issue_ok_acc;
    end else if (!req_valid_q) begin
      req_valid_nxt = issue_ok;
    end
    if (redirect) begin
      req_valid_nxt = 1'b0;
      req_pc_nxt    = redirect_pc_al;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!redirect && bus.fetch_en) state_nxt = ST_FETCH;
      ST_FETCH: if (redirect) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!redirect && (outstanding_nxt == '0)) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      outstanding <= '0;
      occupancy   <= '0;
      req_valid_q <= 1'b0;
      req_pc_q    <= RESET_PC;
      flush_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      occupancy   <= occupancy_nxt;
      req_valid_q <= req_valid_nxt;
      req_pc_q    <= req_pc_nxt;
      flush_q     <= redirect;
    end
  end

  assign bus.ic_req_valid  = req_valid_q;
  assign bus.ic_req_pc     = req_pc_q;
  assign bus.buf_enq_valid = enq;
  assign bus.buf_enq_data  = bus.ic_resp_data;
  assign bus.buf_flush     = flush_q;
  assign bus.busy          = (outstanding != '0);

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q, perf_drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (req_accept && (perf_issue_q != '1)) perf_issue_q <= perf_issue_q + 32'd1;
      if (starved && (perf_stall_q != '1))    perf_stall_q <= perf_stall_q + 32'd1;
      if (resp && !enq && (perf_drop_q != '1)) perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign bus.perf_issue_cnt = perf_issue_q;
  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_drop_cnt  = perf_drop_q;
`endif

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occupancy <= DEPTH_C);
  a_out_bound: assert property (@(posedge clk) disable iff (rst) outstanding <= MAX_C);
  a_resp_owed: assert property (@(posedge clk) disable iff (rst) !(resp && (outstanding == '0)));

endmodule
